uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//   UART receiver consuming the receive-side baud tick from the baud clock generator.
//   The tick runs at 16x the bit rate. Synchronises the serial line, detects and
//   qualifies start bits, and samples data, optional parity and stop mid-bit.
//   Delivers the received word with a one-clock done strobe and error flags.
//   Sits between the baud generator (s_tick) and the RX FIFO/host logic.
// PARAMETERS
//   DBIT     8   data bits per frame, legal 5..8
//   OS       16  ticks per bit (oversampling ratio), power of 2, >=8
//   SB_TICK  16  ticks spent in stop state (16=1 stop, 24=1.5, 32=2)
// PORTS
//   clk          in   1  system clock, all logic on posedge
//   rst          in   1  synchronous, active-low reset
//   s_tick       in   1  oversample tick, 1 clk wide, from baud generator
//   rx           in   1  asynchronous serial line, idle high
//   parity_en    in   1  1 = parity bit present after data
//   parity_odd   in   1  1 = odd parity, 0 = even (ignored if !parity_en)
//   rx_dout      out  8  received word, LSB-first on line, right-justified, upper bits 0
//   rx_done_tick out  1  1-clk pulse: rx_dout/flags updated
//   frame_err    out  1  stop bit sampled low (valid with done, held until next done)
//   parity_err   out  1  parity mismatch (valid with done, held until next done)
//   busy         out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//     - state=IDLE; rx_dout=0; rx_done_tick=0; frame_err=0; parity_err=0; busy=0.
//     - Sync flops=1; counters=0. Abort mid-frame silently, no done pulse.
//   Input: rx passes through 2 flops -> rx_s; rx_p = rx_s delayed 1 clk.
//   FSM IDLE/START/DATA/PARITY/STOP; s_cnt 0..max(OS,SB_TICK)-1, n_cnt 0..DBIT-1:
//     IDLE:   rx_p==1 && rx_s==0 (falling edge) -> START, s_cnt=0.
//             Latch parity_en/parity_odd for the whole frame.
//             A held-low line never re-triggers.
//     START:  on s_tick: if s_cnt==OS/2-1, then rx_s==0 -> DATA, s_cnt=0, n_cnt=0;
//             rx_s==1 -> IDLE (glitch, no done); else s_cnt++.
//     DATA:   on s_tick: if s_cnt==OS-1, then shift rx_s into data MSB end, s_cnt=0.
//             Then n_cnt==DBIT-1 -> PARITY if parity_en else STOP; else n_cnt++.
//             Else s_cnt++.
//     PARITY: on s_tick at s_cnt==OS-1: store p=rx_s, s_cnt=0 -> STOP.
//     STOP:   on s_tick at s_cnt==SB_TICK-1: -> IDLE.
//             Next clk: rx_done_tick=1; rx_dout=data.
//             frame_err=~rx_s (sampled on that tick).
//             parity_err = parity_en & (^data ^ p ^ parity_odd).
//   Clocking and timing:
//     - Counters advance only on s_tick cycles; no s_tick -> all state holds.
//     - Latency: done asserts exactly 1 clk after the final STOP tick.
//     - A new start edge is accepted in the same clk done is asserted (back-to-back).
//   Inputs and errors:
//     - parity_en/parity_odd changes mid-frame: no effect until the next frame.
//     - Frame error: data still delivered (break -> rx_dout=0x00, frame_err=1).
// TESTING
//   (tick every 4 clk, OS=16, DBIT=8)
//   1. 8N1 frame 0x55 -> one done pulse; rx_dout=0x55, frame_err=0, parity_err=0.
//      Done at 9.5 bit times + 1 clk after start edge.
//   2. rx low for 4 ticks then high -> START aborts to IDLE.
//      No done pulse; busy falls after tick 8.
//   3. parity_en=1, parity_odd=0, frame 0xA3 with parity bit 1 -> rx_dout=0xA3, parity_err=1.
//      Same frame with parity bit 0 -> parity_err=0.
//   4. Frame 0x3C with stop bit 0 -> rx_dout=0x3C, frame_err=1.
//      Line held low afterwards -> no further done until a new high->low edge.
//   5. rst=0 for 1 clk during data bit 4 -> outputs zero, no done.
//      Following clean 0xC7 frame -> rx_dout=0xC7.
//   6. Back-to-back 0x01,0xFE with one stop bit and zero idle -> two done pulses, in order.
//      Then DBIT=5: frame 0x1F -> rx_dout=0x1F.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with optional parity, frame/parity error flags
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [7:0] rx_dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] data_q, data_d;
  logic [2:0]      sync_q, sync_d;
  logic            pen_q, pen_d, podd_q, podd_d, p_q, p_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d, ferr_q, ferr_d, perr_q, perr_d;
  logic            rx_s, rx_p;
  assign rx_s = sync_q[1];
  assign rx_p = sync_q[2];
  always_comb begin
    sync_d  = {sync_q[1:0], rx};
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    data_d  = data_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    p_d     = p_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: if (rx_p && !rx_s) begin
        state_d = START;
        s_cnt_d = '0;
        pen_d   = parity_en;
        podd_d  = parity_odd;
      end
      START: if (s_tick) begin
        if (s_cnt_q == SW'(OS / 2 - 1)) begin
          state_d = rx_s ? IDLE : DATA;
          s_cnt_d = '0;
          n_cnt_d = '0;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      DATA: if (s_tick) begin
        if (s_cnt_q == SW'(OS - 1)) begin
          data_d  = {rx_s, data_q[DBIT-1:1]};
          s_cnt_d = '0;
          if (n_cnt_q == NW'(DBIT - 1)) state_d = pen_q ? PARITY : STOP;
          else n_cnt_d = n_cnt_q + 1'b1;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      PARITY: if (s_tick) begin
        if (s_cnt_q == SW'(OS - 1)) begin
          p_d     = rx_s;
          s_cnt_d = '0;
          state_d = STOP;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      STOP: if (s_tick) begin
        if (s_cnt_q == SW'(SB_TICK - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dout_d  = 8'(data_q);
          ferr_d  = ~rx_s;
          perr_d  = pen_q & (^data_q ^ p_q ^ podd_q);
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      data_q  <= '0;
      sync_q  <= 3'b111;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      data_q  <= data_d;
      sync_q  <= sync_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end
  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;
  assign busy         = state_q != IDLE;
endmodule
